// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store sequencer.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_HALF = 1'b1;

  localparam int unsigned MEM_WORDS_DEFAULT = 512;

  // Misaligned halfword or word index beyond the end of data memory.
  function automatic logic is_bad_access(logic size, logic [15:0] addr, int unsigned mem_words);
    return ((size == SIZE_HALF) && addr[0]) || (32'(addr[15:1]) >= mem_words);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic                  req_size;
  logic                  req_signed;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_error;

  logic [DATA_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write_enable;
  logic                  mem_read_enable;
  logic [DATA_WIDTH-1:0] mem_read_data;

  // Requester and memory side.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_write_data, mem_write_enable, mem_read_enable
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_write_data, mem_write_enable, mem_read_enable
  );
endinterface

// File: rtl/load_store_unit_byte_lane.sv
// Byte lane extract with sign/zero extension, and lane merge for byte stores.
module byte_lane_unit (
  input  logic [15:0] word,
  input  logic        lane,
  input  logic        sign_ext,
  input  logic [7:0]  new_byte,
  output logic [15:0] load_data,
  output logic [15:0] merged
);
  logic [7:0] sel;

  always_comb begin
    sel       = lane ? word[15:8] : word[7:0];
    load_data = {{8{sign_ext & sel[7]}}, sel};
    merged    = lane ? {new_byte, word[7:0]} : {word[15:8], new_byte};
  end
endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer driving a word-addressed 16-bit data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MEM_WORDS  = MEM_WORDS_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  state_t state, next_state;

  logic        r_write;
  logic        r_size;
  logic        r_signed;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] old_word;
  logic [15:0] rdata_q;
  logic        error_q;

  logic [15:0] lane_word;
  logic [15:0] load_data;
  logic [15:0] merged;

  // One lane unit serves both paths: live read data in ACCESS, saved word in WRITE.
  assign lane_word = (state == ST_WRITE) ? old_word : bus.mem_read_data;

  byte_lane_unit u_lane (
    .word      (lane_word),
    .lane      (r_addr[0]),
    .sign_ext  (r_signed),
    .new_byte  (r_wdata[7:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:
        if (bus.req_valid)
          next_state = is_bad_access(bus.req_size, bus.req_addr, MEM_WORDS) ? ST_RESP : ST_ACCESS;
      ST_ACCESS: next_state = (r_write && r_size == SIZE_BYTE) ? ST_WRITE : ST_RESP;
      ST_WRITE:  next_state = ST_RESP;
      ST_RESP:   if (bus.resp_ready) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_size   <= SIZE_BYTE;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      old_word <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (bus.req_valid) begin
            r_write  <= bus.req_write;
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            rdata_q  <= '0;
            error_q  <= is_bad_access(bus.req_size, bus.req_addr, MEM_WORDS);
          end
        ST_ACCESS:
          if (!r_write)
            rdata_q <= (r_size == SIZE_HALF) ? bus.mem_read_data : load_data;
          else if (r_size == SIZE_BYTE)
            old_word <= bus.mem_read_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready        = (state == ST_IDLE);
    bus.resp_valid       = (state == ST_RESP);
    bus.resp_rdata       = rdata_q;
    bus.resp_error       = error_q;
    bus.mem_address      = '0;
    bus.mem_write_data   = '0;
    bus.mem_write_enable = 1'b0;
    bus.mem_read_enable  = 1'b0;
    case (state)
      ST_ACCESS: begin
        bus.mem_address = {1'b0, r_addr[15:1]};
        if (r_write && r_size == SIZE_HALF) begin
          bus.mem_write_enable = 1'b1;
          bus.mem_write_data   = r_wdata;
        end else begin
          bus.mem_read_enable = 1'b1;
        end
      end
      ST_WRITE: begin
        bus.mem_address      = {1'b0, r_addr[15:1]};
        bus.mem_write_enable = 1'b1;
        bus.mem_write_data   = merged;
      end
      default: ;
    endcase
    // Gating by reset keeps an aborted byte store from committing its write.
    if (reset) begin
      bus.mem_address      = '0;
      bus.mem_write_data   = '0;
      bus.mem_write_enable = 1'b0;
      bus.mem_read_enable  = 1'b0;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 512-word data memory.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_WIDTH(16)) bus ();

  load_store_unit #(.DATA_WIDTH(16), .MEM_WORDS(512)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [512];
  logic        pre_we = 1'b0;
  logic [8:0]  pre_idx = '0;
  logic [15:0] pre_data = '0;

  assign bus.mem_read_data = mem[bus.mem_address[8:0]];

  int          strobes = 0;
  int          wr_strobes = 0;
  int          overlaps = 0;
  logic [15:0] last_maddr = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (bus.mem_write_enable) mem[bus.mem_address[8:0]] <= bus.mem_write_data;
    if (bus.mem_write_enable || bus.mem_read_enable) begin
      strobes    <= strobes + 1;
      last_maddr <= bus.mem_address;
    end
    if (bus.mem_write_enable) wr_strobes <= wr_strobes + 1;
    if (bus.mem_write_enable && bus.mem_read_enable) overlaps <= overlaps + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [8:0] idx, input logic [15:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic        sz;
    logic        sg;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [15:0] exp_maddr;
    logic        chk_mem;
    logic [8:0]  mem_idx;
    logic [15:0] exp_mem;
  } vec_t;

  vec_t vecs [14];

  task automatic run_vec(input int n, input vec_t v);
    int lat;
    int s0;
    string tag;
    tag = $sformatf("v%0d", n);
    @(negedge clk);
    chk({tag, "_req_ready"}, bus.req_ready, 1'b1);
    bus.req_valid = 1'b1; bus.req_write = v.wr; bus.req_size = v.sz;
    bus.req_signed = v.sg; bus.req_addr = v.addr; bus.req_wdata = v.wdata;
    s0 = strobes;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin lat = c; break; end
    end
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_rdata"}, bus.resp_rdata, v.exp_rdata);
    chk({tag, "_error"}, bus.resp_error, v.exp_err);
    if (v.exp_err) begin
      chk({tag, "_strobes"}, strobes - s0, 0);
    end else begin
      chk({tag, "_strobes"}, strobes - s0, v.exp_lat - 1);
      chk({tag, "_maddr"}, last_maddr, v.exp_maddr);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    if (v.chk_mem) chk({tag, "_mem"}, mem[v.mem_idx], v.exp_mem);
  endtask

  initial begin
    int s0;
    int w0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 1'b0;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b0;

    //         wr    sz    sg    addr      wdata     rdata     err   lat  maddr     chk   idx     mem
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 2, 16'h0008, 1'b1, 9'h008, 16'hBEEF};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 2, 16'h0008, 1'b0, 9'h000, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0021, 16'h0000, 16'hFF80, 1'b0, 2, 16'h0010, 1'b0, 9'h000, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000, 16'h0080, 1'b0, 2, 16'h0010, 1'b0, 9'h000, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'h007F, 1'b0, 2, 16'h0010, 1'b0, 9'h000, 16'h0000};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000, 16'hFFBE, 1'b0, 2, 16'h0008, 1'b0, 9'h000, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0031, 16'h00AB, 16'h0000, 1'b0, 3, 16'h0018, 1'b1, 9'h018, 16'hAB34};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0030, 16'h77CD, 16'h0000, 1'b0, 3, 16'h0018, 1'b1, 9'h018, 16'hABCD};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'hABCD, 1'b0, 2, 16'h0018, 1'b0, 9'h000, 16'h0000};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1, 1, 16'h0000, 1'b0, 9'h000, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 1, 16'h0000, 1'b0, 9'h000, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0401, 16'h0055, 16'h0000, 1'b1, 1, 16'h0000, 1'b0, 9'h000, 16'h0000};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h03FF, 16'h0000, 16'h005A, 1'b0, 2, 16'h01FF, 1'b0, 9'h000, 16'h0000};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 16'h0003, 16'h9999, 16'h0000, 1'b1, 1, 16'h0000, 1'b1, 9'h001, 16'h0000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_rdata", bus.resp_rdata, 16'h0000);
    chk("rst_resp_error", bus.resp_error, 1'b0);
    chk("rst_mem_strobes", {bus.mem_write_enable, bus.mem_read_enable}, 2'b00);
    chk("rst_mem_addr", bus.mem_address, 16'h0000);
    reset = 1'b0;

    preload(9'h010, 16'h807F);
    preload(9'h018, 16'h1234);
    preload(9'h1FF, 16'h5A00);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Response backpressure with a competing request held on the inputs.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 1'b1;
    bus.req_signed = 1'b0; bus.req_addr = 16'h0010;
    @(posedge clk);
    #1 bus.req_write = 1'b1; bus.req_wdata = 16'h1111;
    @(negedge clk);
    @(negedge clk);
    s0 = strobes;
    for (int c = 0; c < 5; c++) begin
      chk("bp_resp_valid", bus.resp_valid, 1'b1);
      chk("bp_rdata", bus.resp_rdata, 16'hBEEF);
      chk("bp_req_ready", bus.req_ready, 1'b0);
      @(negedge clk);
    end
    chk("bp_no_strobes", strobes - s0, 0);
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_ready", bus.req_ready, 1'b1);
    chk("bp_mem_kept", mem[8], 16'hBEEF);

    // Reset asserted while a byte store sits in WRITE.
    w0 = wr_strobes;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 1'b0;
    bus.req_addr = 16'h0031; bus.req_wdata = 16'h00EE;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rw_access_read", bus.mem_read_enable, 1'b1);
    @(negedge clk);
    chk("rw_write_state", bus.mem_write_enable, 1'b1);
    reset = 1'b1;
    #1 chk("rw_we_gated", bus.mem_write_enable, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rw_req_ready", bus.req_ready, 1'b1);
    chk("rw_resp_valid", bus.resp_valid, 1'b0);
    chk("rw_no_write", wr_strobes - w0, 0);
    chk("rw_mem_kept", mem[9'h018], 16'hABCD);

    chk("strobe_overlap", overlaps, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store sequencer between the processor control/ALU and `data_memory_unit`. It accepts one memory request per handshake, translates byte addresses into word addresses for the 16-bit-wide, word-addressed data memory, and performs sign/zero-extended byte loads. Byte stores use read-modify-write and misaligned or out-of-range accesses are reported as errors. It sits directly upstream of `data_memory_unit` and drives its address, write_data, write_enable and read_enable ports.

## Interface
- `DATA_WIDTH`, 16, data and address width (fixed at 16 for this core).
- `MEM_WORDS`, 512, number of 16-bit words in data memory; word addresses ≥ MEM_WORDS are out of range.
- `clk` in 1: single clock; everything updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 1: 0 = byte, 1 = halfword (16-bit word).
- `req_signed` in 1: byte load sign-extends when 1, zero-extends when 0.
- `req_addr` in 16: byte address.
- `req_wdata` in 16: store data; a byte store uses bits [7:0].
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer accepts response.
- `resp_rdata` out 16: load result; 0 for stores and errors.
- `resp_error` out 1: misaligned or out-of-range request.
- `mem_address` out 16: word address, {1'b0, addr[15:1]}.
- `mem_write_data` out 16.
- `mem_write_enable` out 1.
- `mem_read_enable` out 1.
- `mem_read_data` in 16: combinational read data from the memory in the same cycle.

## Operation
- **States:** IDLE, ACCESS, WRITE, RESP.
- **IDLE:**
  - `req_ready` is 1.
  - On `req_valid`, register the request fields and go to ACCESS.
  - If the request is a halfword access with `req_addr[0]` = 1, or if `req_addr[15:1]` ≥ MEM_WORDS: set error, skip memory, go to RESP.
- **ACCESS:**
  - Drive `mem_address` from the registered address.
  - Halfword load: `mem_read_enable` = 1; capture `mem_read_data` into `resp_rdata`; go to RESP.
  - Byte load: `mem_read_enable` = 1. Extract lane: `addr[0]` = 0 selects [7:0], 1 selects [15:8] (little-endian). Extend per `req_signed`, capture, go to RESP.
  - Halfword store: `mem_write_enable` = 1, `mem_write_data` = wdata, go to RESP.
  - Byte store: `mem_read_enable` = 1; capture the old word; go to WRITE.
- **WRITE (byte store only):**
  - `mem_write_enable` = 1.
  - `mem_write_data` = old word with the selected lane replaced by wdata[7:0], other lane unchanged.
  - Go to RESP.
- **RESP:**
  - `resp_valid` = 1; `resp_rdata` and `resp_error` are held stable.
  - On `resp_ready`, go to IDLE.
  - No new request is accepted in the same cycle.
- **Memory strobes:**
  - `mem_read_enable` and `mem_write_enable` are never both 1.
  - Both are 0 in IDLE and RESP.
  - Both are forced to 0 while `reset` = 1.

## Timing
- **Reset values:** state IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_error` = 0, `mem_*` outputs = 0.
- **Reset mid-operation:** the operation is aborted at the next edge with no memory write committed (enables are gated by `reset`). A byte store reset in WRITE leaves memory unchanged.
- **Latency,** from the accept edge T to `resp_valid`:
  - load, halfword store, or error: resp_valid rises at T+2 for valid accesses and T+1 for errors;
  - byte store: resp_valid rises at T+3.
- **Back-to-back throughput:** one request per 3 cycles minimum when `resp_ready` is held high (4 for byte stores).
- **Input stability:** request inputs are ignored outside IDLE; the registered copy is used throughout.
- **Response stall:** `resp_valid` stays high indefinitely while `resp_ready` = 0.
- **Memory commit:** the memory commits a write on the rising edge that ends ACCESS or WRITE.

## Structure
- **Package `lsu_pkg`:**
  - state enum (IDLE, ACCESS, WRITE, RESP);
  - size codes SIZE_BYTE = 0, SIZE_HALF = 1;
  - MEM_WORDS default.
- **Sub-module `byte_lane_unit`:** combinational lane extract plus sign/zero extend, and lane merge for stores. It is instantiated once and shared by the load and store paths.
- **Top level:** the FSM, the request and response registers, and the memory port drive.

## Test plan
- **Halfword round trip:** store 0xBEEF at addr 0x0010, then load halfword from 0x0010 → `mem_address` = 0x0008; `resp_rdata` = 0xBEEF at T+2; `resp_error` = 0.
- **Byte loads:** with word 0x80 7F at 0x0020, byte load from 0x0021 signed → 0xFF80; unsigned → 0x0080. Byte load from 0x0020 signed → 0x007F.
- **Byte store read-modify-write:** word 0x1234 at 0x0030, byte store 0xAB to 0x0031 → ACCESS read, then WRITE of 0xAB34 at `mem_address` 0x0018; `resp_valid` at T+3.
- **Errors:** halfword load at 0x0011 → `resp_error` = 1 at T+1, `resp_rdata` = 0, no memory strobes. Halfword load at 0x0400 (word 512) → `resp_error` = 1.
- **Response backpressure:** hold `resp_ready` = 0 for 5 cycles → `resp_valid` and data stay stable, `req_ready` = 0, and a new `req_valid` is ignored until after the accept.
- **Reset in WRITE:** assert `reset` during the WRITE state of a byte store → no write enable seen, memory word unchanged, and the next cycle shows `req_ready` = 1 and `resp_valid` = 0.
